// File: rtl/key_cmd_pkg.sv
// Shared command words, FSM state encoding and key-priority helpers for key_command_encoder.
// Command constants must match the hood control FSM's decode.
package key_cmd_pkg;

  localparam logic [5:0] CMD_IDLE  = 6'b100000;
  localparam logic [5:0] CMD_MENU  = 6'b110000;
  localparam logic [5:0] CMD_LVL1  = 6'b101000;
  localparam logic [5:0] CMD_LVL2  = 6'b100100;
  localparam logic [5:0] CMD_STORM = 6'b100010;
  localparam logic [5:0] CMD_CLEAN = 6'b100001;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Fixed priority menu > lvl1 > lvl2 > storm > clean; losers are simply dropped.
  function automatic logic [4:0] pick_winner(input logic [4:0] edges);
    if (edges[4])      return CMD_MENU[4:0];
    else if (edges[3]) return CMD_LVL1[4:0];
    else if (edges[2]) return CMD_LVL2[4:0];
    else if (edges[1]) return CMD_STORM[4:0];
    else if (edges[0]) return CMD_CLEAN[4:0];
    else               return CMD_IDLE[4:0];
  endfunction

  function automatic logic multi_hot(input logic [4:0] v);
    return (v & (v - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a tick-driven debounce counter.
// rise pulses for one cycle in the same cycle stable goes 0 -> 1.
module key_debounce #(
  parameter int DEB_TICKS = 20,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments let the synchroniser stages shift in one edge without ordering races.
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (tick) begin
        // cnt never passes CNT_LAST, so it cannot wrap.
        if (cnt >= CNT_LAST) begin
          stable <= sync_q2;
          rise   <= sync_q2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_command_encoder.sv
// Debounces power switch and five keys and turns key presses into held command words for the control FSM.
// Optional auto-repeat of a held key is enabled by defining KEY_REPEAT_EN.
module key_command_encoder
  import key_cmd_pkg::*;
#(
  parameter int DEB_TICKS    = 20,
  parameter int HOLD_TICKS   = 4,
  parameter int REPEAT_TICKS = 100,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       power_sw,
  input  logic [4:0] key_raw,
  input  logic       cmd_ack,
  output logic [5:0] cmd,
  output logic       cmd_valid,
  output logic       multi_press
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

  logic             en;
  logic             power_rise_unused;
  logic [4:0]       key_stable;
  logic [4:0]       key_rise;
  state_t           state_q, state_d;
  logic [4:0]       cmd_lo_q, cmd_lo_d;
  logic             en_q;
  logic             multi_q;
  logic [CNT_W-1:0] hold_q, hold_d;
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [4:0]       last_q, last_d;
`else
  // Repeat interval has no meaning without the repeat logic.
  localparam int repeat_ticks_unused = REPEAT_TICKS;
`endif

  key_debounce #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_deb_power (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .raw    (power_sw),
    .stable (en),
    .rise   (power_rise_unused)
  );

  for (genvar i = 0; i < 5; i++) begin : g_key
    key_debounce #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .raw    (key_raw[i]),
      .stable (key_stable[i]),
      .rise   (key_rise[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_lo_q <= '0;
      en_q     <= 1'b0;
      multi_q  <= 1'b0;
      hold_q   <= '0;
`ifdef KEY_REPEAT_EN
      rep_q    <= '0;
      last_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_lo_q <= cmd_lo_d;
      en_q     <= en;
      multi_q  <= multi_hot(key_rise);
      hold_q   <= hold_d;
`ifdef KEY_REPEAT_EN
      rep_q    <= rep_d;
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cmd_lo_d = cmd_lo_q;
    hold_d   = hold_q;
`ifdef KEY_REPEAT_EN
    rep_d    = rep_q;
    last_d   = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cmd_lo_d = CMD_IDLE[4:0];
        hold_d   = '0;
`ifdef KEY_REPEAT_EN
        rep_d    = '0;
`endif
        if (en && (key_rise != 5'd0)) begin
          state_d  = S_HOLD;
          cmd_lo_d = pick_winner(key_rise);
`ifdef KEY_REPEAT_EN
          last_d   = pick_winner(key_rise);
`endif
        end
      end
      S_HOLD: begin
        // Power loss, ack and timeout all collapse into one exit.
        if (!en || cmd_ack || (tick && (hold_q >= HOLD_LAST))) begin
          state_d  = S_RELEASE;
          cmd_lo_d = CMD_IDLE[4:0];
          hold_d   = '0;
        end else if (tick) begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (key_stable == 5'd0) begin
          state_d = S_IDLE;
`ifdef KEY_REPEAT_EN
        end else if (en && (key_stable == last_q)) begin
          if (tick) begin
            if (rep_q >= REPEAT_LAST) begin
              state_d  = S_HOLD;
              cmd_lo_d = last_q;
              rep_d    = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end else begin
          rep_d = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd         = {en_q, cmd_lo_q};
  assign cmd_valid   = (state_q == S_HOLD);
  assign multi_press = multi_q;

endmodule

// File: tb/tb_key_command_encoder.sv
// Self-checking bench for key_command_encoder: directed scenarios plus randomized traffic against a behavioural model.
// Define KEY_REPEAT_EN for both bench and RTL to exercise auto-repeat.
module tb_key_command_encoder;

  localparam int DEB_TICKS    = 4;
  localparam int HOLD_TICKS   = 3;
  localparam int REPEAT_TICKS = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       power_sw;
  logic [4:0] key_raw;
  logic       cmd_ack;
  logic [5:0] cmd;
  logic       cmd_valid;
  logic       multi_press;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  key_command_encoder #(
    .DEB_TICKS    (DEB_TICKS),
    .HOLD_TICKS   (HOLD_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .power_sw    (power_sw),
    .key_raw     (key_raw),
    .cmd_ack     (cmd_ack),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .multi_press (multi_press)
  );

  always #5 clk = ~clk;

  // Behavioural model: index 5 is the power switch, 4..0 the keys.
  int         m_s1[6], m_s2[6], m_st[6], m_cnt[6], m_rise[6];
  int         m_mode;  // 0 waiting, 1 presenting, 2 waiting for release
  int         m_hold, m_rep, m_last;
  logic [4:0] m_lo;
  logic       m_en_q, m_multi;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_rise[i] = 0;
    end
    m_mode = 0; m_hold = 0; m_rep = 0; m_last = 0;
    m_lo = '0; m_en_q = 1'b0; m_multi = 1'b0;
  endtask

  task automatic model_step();
    int n_rise, win, keys, en, rawv;
    en   = m_st[5];
    keys = 0;
    for (int i = 0; i < 5; i++) keys += m_st[i] << i;
    n_rise = 0;
    win    = -1;
    for (int i = 4; i >= 0; i--) begin
      if (m_rise[i] != 0) begin
        n_rise++;
        if (win < 0) win = i;
      end
    end
    m_multi = (n_rise > 1);
    m_en_q  = (en != 0);
    case (m_mode)
      0: begin
        m_hold = 0;
        m_rep  = 0;
        if (en != 0 && win >= 0) begin
          m_mode = 1;
          m_lo   = 5'(1 << win);
          m_last = win;
        end
      end
      1: begin
        if (en == 0 || cmd_ack || (tick && m_hold + 1 >= HOLD_TICKS)) begin
          m_mode = 2;
          m_lo   = '0;
          m_hold = 0;
        end else if (tick) begin
          m_hold++;
        end
      end
      default: begin
        if (keys == 0) begin
          m_mode = 0;
`ifdef KEY_REPEAT_EN
        end else if (en != 0 && keys == (1 << m_last)) begin
          if (tick) begin
            if (m_rep + 1 >= REPEAT_TICKS) begin
              m_mode = 1;
              m_lo   = 5'(1 << m_last);
              m_rep  = 0;
            end else begin
              m_rep++;
            end
          end
        end else begin
          m_rep = 0;
`endif
        end
      end
    endcase
    for (int i = 0; i < 6; i++) begin
      rawv      = (i == 5) ? int'(power_sw) : int'(key_raw[i]);
      m_rise[i] = 0;
      if (m_s2[i] == m_st[i]) begin
        m_cnt[i] = 0;
      end else if (tick) begin
        if (m_cnt[i] + 1 >= DEB_TICKS) begin
          m_st[i]   = m_s2[i];
          m_rise[i] = m_s2[i];
          m_cnt[i]  = 0;
        end else begin
          m_cnt[i]++;
        end
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = rawv;
    end
  endtask

  function automatic logic [7:0] exp_out();
    return {m_en_q, m_lo, (m_mode == 1), m_multi};
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic settle(input string tag, input int n);
    key_raw = '0;
    cmd_ack = 1'b0;
    for (int k = 0; k < n; k++) begin
      cycle();
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL %s cyc=%0d got {cmd,valid,multi}=%b want=%b", tag, cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b1; power_sw = 1'b0; key_raw = '0; cmd_ack = 1'b0;
    model_reset();
    repeat (3) cycle();
    checks++;
    if ({cmd, cmd_valid, multi_press} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state got {cmd,valid,multi}=%b want=%b", {cmd, cmd_valid, multi_press}, 8'b0);
    end
    rst_n = 1'b1;
    settle("reset_release", 3);
  endtask

  task automatic test_single_key();
    int vcount = 0, issues = 0;
    logic prev = 1'b0;
    power_sw = 1'b1;
    settle("power_up", 10);
    checks++;
    if (cmd !== 6'b100000) begin
      errors++;
      $display("FAIL power_up_idle got cmd=%b want=%b", cmd, 6'b100000);
    end
    key_raw = 5'b01000;
    for (int k = 0; k < 20; k++) begin
      cycle();
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL single_key cyc=%0d got=%b want=%b", cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
      if (cmd_valid) begin
        vcount++;
        checks++;
        if (cmd !== 6'b101000) begin
          errors++;
          $display("FAIL single_key_word got cmd=%b want=%b", cmd, 6'b101000);
        end
      end
      if (cmd_valid && !prev) issues++;
      prev = cmd_valid;
    end
    checks++;
    if (vcount != HOLD_TICKS || issues != 1) begin
      errors++;
      $display("FAIL single_key_hold got valid_cycles=%0d issues=%0d want %0d and 1", vcount, issues, HOLD_TICKS);
    end
    settle("single_key_release", 12);
  endtask

  task automatic test_bounce();
    int issues = 0, at = -1;
    logic prev = 1'b0;
    for (int k = 0; k < 30; k++) begin
      key_raw[4] = (k < 12) ? ((k / 2) % 2 == 0) : 1'b1;
      cycle();
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%b want=%b", cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
      if (cmd_valid && !prev) begin
        issues++;
        if (at < 0) at = k;
      end
      prev = cmd_valid;
    end
    checks++;
    if (issues != 1 || at != 12 + 2 + DEB_TICKS) begin
      errors++;
      $display("FAIL bounce_issue got issues=%0d first_at=%0d want 1 and %0d", issues, at, 12 + 2 + DEB_TICKS);
    end
    settle("bounce_release", 12);
  endtask

  task automatic test_multi_press();
    int issues = 0, pulses = 0;
    logic prev = 1'b0;
    key_raw = 5'b10001;
    for (int k = 0; k < 25; k++) begin
      cycle();
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL multi_press cyc=%0d got=%b want=%b", cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
      if (multi_press) pulses++;
      if (cmd_valid && !prev) begin
        issues++;
        checks++;
        if (cmd !== 6'b110000) begin
          errors++;
          $display("FAIL multi_press_winner got cmd=%b want=%b", cmd, 6'b110000);
        end
      end
      prev = cmd_valid;
    end
    checks++;
    if (issues != 1 || pulses != 1) begin
      errors++;
      $display("FAIL multi_press_count got issues=%0d pulses=%0d want 1 and 1", issues, pulses);
    end
    settle("multi_release", 12);
  endtask

  task automatic test_ack();
    int vcount = 0;
    logic acked = 1'b0;
    key_raw = 5'b00100;
    for (int k = 0; k < 20; k++) begin
      cycle();
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL ack cyc=%0d got=%b want=%b", cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
      if (cmd_valid) vcount++;
      if (cmd_valid && !acked) begin
        cmd_ack = 1'b1;
        acked   = 1'b1;
      end else begin
        cmd_ack = 1'b0;
      end
    end
    checks++;
    if (vcount != 1) begin
      errors++;
      $display("FAIL ack_hold got valid_cycles=%0d want 1", vcount);
    end
    settle("ack_release", 12);
  endtask

  task automatic test_power_off();
    int vcount = 0;
    key_raw = 5'b00010;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) power_sw = 1'b0;
      cycle();
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL power_off cyc=%0d got=%b want=%b", cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
      if (cmd_valid) vcount++;
    end
    checks++;
    if (vcount != 2 || cmd !== 6'b000000) begin
      errors++;
      $display("FAIL power_off_cut got valid_cycles=%0d cmd=%b want 2 and %b", vcount, cmd, 6'b000000);
    end
    settle("power_off_release", 10);
    vcount  = 0;
    key_raw = 5'b00001;
    for (int k = 0; k < 15; k++) begin
      cycle();
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL power_off_press cyc=%0d got=%b want=%b", cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
      if (cmd_valid) vcount++;
    end
    checks++;
    if (vcount != 0) begin
      errors++;
      $display("FAIL power_off_ignored got valid_cycles=%0d want 0", vcount);
    end
    settle("power_off_key_release", 10);
    power_sw = 1'b1;
    settle("power_restore", 10);
  endtask

  task automatic test_async_reset();
    int budget = 0;
    key_raw = 5'b10000;
    while (!cmd_valid && budget < 20) begin
      cycle();
      budget++;
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL async_reset_pre cyc=%0d got=%b want=%b", cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
    end
    checks++;
    if (!cmd_valid) begin
      errors++;
      $display("FAIL async_reset_wait got cmd_valid=0 after %0d cycles want 1", budget);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({cmd, cmd_valid} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_now got cmd=%b valid=%b want 000000 and 0", cmd, cmd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    settle("async_reset_recover", 12);
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    int issues = 0;
    logic prev = 1'b0;
    key_raw = 5'b00001;
    for (int k = 0; k < 30; k++) begin
      cycle();
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL repeat cyc=%0d got=%b want=%b", cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
      if (cmd_valid && !prev) issues++;
      prev = cmd_valid;
    end
    checks++;
    if (issues != 3) begin
      errors++;
      $display("FAIL repeat_count got issues=%0d want 3", issues);
    end
    settle("repeat_release", 12);
  endtask
`endif

  task automatic test_random();
    int dwell = 0;
    for (int k = 0; k < 800; k++) begin
      if (dwell == 0) begin
        key_raw = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
        if ($urandom_range(0, 3) == 0) key_raw = '0;
        dwell = $urandom_range(1, 14);
      end else begin
        dwell--;
      end
      if ($urandom_range(0, 59) == 0) power_sw = ~power_sw;
      cmd_ack = ($urandom_range(0, 5) == 0);
      tick    = ($urandom_range(0, 3) != 0);
      cycle();
      checks++;
      if ({cmd, cmd_valid, multi_press} !== exp_out()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, {cmd, cmd_valid, multi_press}, exp_out());
      end
    end
    tick     = 1'b1;
    power_sw = 1'b1;
    settle("random_drain", 15);
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_multi_press();
    test_ack();
    test_power_off();
    test_async_reset();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
